// File: rtl/dct_rle_encoder.sv
// rtl/dct_rle_encoder.sv - quantize an 8-coefficient DCT block and emit (run, value) tokens plus EOB
// Optional RLE_STATS_EN adds blk_count/tok_count consumed-token counters.
module dct_rle_encoder #(
    parameter int COEF_W = 19,
    parameter int QSHIFT = 4,
    parameter int VAL_W  = 8,
    parameter int RUN_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef RLE_STATS_EN
    output logic [15:0]              blk_count,
    output logic [15:0]              tok_count,
`endif
    input  logic                     en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [COEF_W-1:0] coef0,
    input  logic signed [COEF_W-1:0] coef1,
    input  logic signed [COEF_W-1:0] coef2,
    input  logic signed [COEF_W-1:0] coef3,
    input  logic signed [COEF_W-1:0] coef4,
    input  logic signed [COEF_W-1:0] coef5,
    input  logic signed [COEF_W-1:0] coef6,
    input  logic signed [COEF_W-1:0] coef7,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RUN_W-1:0]         out_run,
    output logic signed [VAL_W-1:0]  out_val,
    output logic                     out_eob
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_EOB} state_t;

    localparam logic signed [COEF_W-1:0] SAT_HI = COEF_W'((1 <<< (VAL_W-1)) - 1);
    localparam logic signed [COEF_W-1:0] SAT_LO = COEF_W'(-(1 <<< (VAL_W-1)));

    state_t                  state;
    logic signed [VAL_W-1:0] q [8];
    logic [2:0]              idx;
    logic [RUN_W-1:0]        run;
    logic                    consume;

    assign consume = out_valid && out_ready && en;

    // Floor shift, then clamp into the token's signed value range.
    function automatic logic signed [VAL_W-1:0] quantize(input logic signed [COEF_W-1:0] c);
        logic signed [COEF_W-1:0] s;
        s = c >>> QSHIFT;
        if (s > SAT_HI)
            s = SAT_HI;
        else if (s < SAT_LO)
            s = SAT_LO;
        return s[VAL_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_run   <= '0;
            out_val   <= '0;
            out_eob   <= 1'b0;
            idx       <= '0;
            run       <= '0;
        end else if (en) begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        q[0]     <= quantize(coef0);
                        q[1]     <= quantize(coef1);
                        q[2]     <= quantize(coef2);
                        q[3]     <= quantize(coef3);
                        q[4]     <= quantize(coef4);
                        q[5]     <= quantize(coef5);
                        q[6]     <= quantize(coef6);
                        q[7]     <= quantize(coef7);
                        idx      <= '0;
                        run      <= '0;
                        in_ready <= 1'b0;
                        state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (q[idx] == '0) begin
                        run <= run + RUN_W'(1);
                        if (idx == 3'd7) begin
                            out_valid <= 1'b1;
                            out_eob   <= 1'b1;
                            out_run   <= run + RUN_W'(1);
                            out_val   <= '0;
                            state     <= S_EOB;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        out_valid <= 1'b1;
                        out_eob   <= 1'b0;
                        out_run   <= run;
                        out_val   <= q[idx];
                        state     <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        run <= '0;
                        // Last coefficient was nonzero: EOB follows back-to-back with run 0.
                        if (idx == 3'd7) begin
                            out_eob <= 1'b1;
                            out_run <= '0;
                            out_val <= '0;
                            state   <= S_EOB;
                        end else begin
                            out_valid <= 1'b0;
                            idx       <= idx + 3'd1;
                            state     <= S_SCAN;
                        end
                    end
                end
                S_EOB: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef RLE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_count <= '0;
            tok_count <= '0;
        end else if (consume) begin
            tok_count <= tok_count + 16'd1;
            if (state == S_EOB)
                blk_count <= blk_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dct_rle_encoder.sv
// tb/tb_dct_rle_encoder.sv - directed and randomized token-stream checks for dct_rle_encoder
module tb_dct_rle_encoder;

    localparam int COEF_W = 19;
    localparam int QSHIFT = 4;
    localparam int VAL_W  = 8;
    localparam int RUN_W  = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     en;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [COEF_W-1:0] coef [8];
    logic                     out_valid;
    logic                     out_ready;
    logic [RUN_W-1:0]         out_run;
    logic signed [VAL_W-1:0]  out_val;
    logic                     out_eob;
`ifdef RLE_STATS_EN
    logic [15:0]              blk_count;
    logic [15:0]              tok_count;
`endif

    dct_rle_encoder #(
        .COEF_W(COEF_W), .QSHIFT(QSHIFT), .VAL_W(VAL_W), .RUN_W(RUN_W)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef RLE_STATS_EN
        .blk_count(blk_count),
        .tok_count(tok_count),
`endif
        .en(en),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .coef0(coef[0]), .coef1(coef[1]), .coef2(coef[2]), .coef3(coef[3]),
        .coef4(coef[4]), .coef5(coef[5]), .coef6(coef[6]), .coef7(coef[7]),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_run(out_run),
        .out_val(out_val),
        .out_eob(out_eob)
    );

    always #5 clk = ~clk;

    typedef struct {
        int run;
        int val;
        int eob;
    } tok_t;

    tok_t exp_q[$];
    int   coef_a [8];
    int   vectors     = 0;
    int   miscompares = 0;
    int   tok_done    = 0;
    int   blk_done    = 0;

    task automatic check(input string tag, input logic signed [31:0] obs, input int expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int quant(input int c);
        int d;
        int q;
        d = 1 << QSHIFT;
        q = c / d;
        if (c < 0 && q * d != c)
            q = q - 1;
        if (q > (1 << (VAL_W-1)) - 1)
            q = (1 << (VAL_W-1)) - 1;
        if (q < -(1 << (VAL_W-1)))
            q = -(1 << (VAL_W-1));
        return q;
    endfunction

    task automatic build_expected();
        int   zeros;
        int   q;
        tok_t t;
        zeros = 0;
        for (int i = 0; i < 8; i++) begin
            q = quant(coef_a[i]);
            if (q == 0) begin
                zeros++;
            end else begin
                t.run = zeros; t.val = q; t.eob = 0;
                exp_q.push_back(t);
                zeros = 0;
            end
        end
        t.run = zeros; t.val = 0; t.eob = 1;
        exp_q.push_back(t);
    endtask

    task automatic set_block(input int a0, input int a1, input int a2, input int a3,
                             input int a4, input int a5, input int a6, input int a7);
        coef_a[0] = a0; coef_a[1] = a1; coef_a[2] = a2; coef_a[3] = a3;
        coef_a[4] = a4; coef_a[5] = a5; coef_a[6] = a6; coef_a[7] = a7;
    endtask

    task automatic apply_block();
        build_expected();
        for (int i = 0; i < 8; i++)
            coef[i] = COEF_W'(coef_a[i]);
        in_valid = 1'b1;
        en       = 1'b1;
        for (int k = 0; k < 40 && !in_ready; k++)
            @(negedge clk);
        check("accept_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("in_ready_low_after_accept", in_ready, 0);
    endtask

    task automatic drain(input int ready_pct, input int en_pct, input int stall, output int first_cyc);
        int   cyc;
        int   left;
        bit   done;
        bit   held;
        bit   fire;
        int   pr, pv, pe;
        tok_t t;
        cyc = 1; done = 0; held = 0; left = stall;
        pr = 0; pv = 0; pe = 0;
        first_cyc = -1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                if (first_cyc < 0)
                    first_cyc = cyc;
                if (held) begin
                    check("stable_run", out_run, pr);
                    check("stable_val", out_val, pv);
                    check("stable_eob", out_eob, pe);
                end
            end
            if (out_valid && left > 0) begin
                out_ready = 1'b0;
                en        = 1'b1;
                check("stall_in_ready", in_ready, 0);
                left--;
            end else begin
                out_ready = ($urandom_range(99) < ready_pct);
                en        = ($urandom_range(99) < en_pct);
            end
            fire = out_valid && out_ready && en;
            if (fire) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_token", exp_q.size(), 1);
                    done = 1;
                end else begin
                    t = exp_q.pop_front();
                    check("tok_run", out_run, t.run);
                    check("tok_val", out_val, t.val);
                    check("tok_eob", out_eob, t.eob);
                    tok_done++;
                    if (t.eob != 0) begin
                        blk_done++;
                        done = 1;
                    end
                end
            end
            held = out_valid && !fire;
            pr = int'(out_run);
            pv = int'(out_val);
            pe = int'(out_eob);
        end
        check("drain_done", done, 1);
        check("queue_empty", exp_q.size(), 0);
        exp_q.delete();
        en = 1'b1;
    endtask

    initial begin
        int fc;
        int sel;
        rst       = 1'b1;
        en        = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            coef[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_run", out_run, 0);
        check("rst_out_val", out_val, 0);
        check("rst_out_eob", out_eob, 0);
        rst = 1'b0;
        en  = 1'b1;

        set_block(0, 0, 0, 0, 0, 0, 0, 0);
        apply_block();
        drain(100, 100, 0, fc);
        check("zero_block_latency", fc, 9);

        set_block(32, 0, 0, -48, 0, 0, 0, 0);
        apply_block();
        drain(100, 100, 0, fc);
        check("first_token_latency", fc, 2);

        set_block(15, -1, 5000, -5000, 0, 0, 0, 16);
        apply_block();
        drain(100, 100, 0, fc);

`ifdef RLE_STATS_EN
        @(negedge clk);
        check("stats_blk_3", blk_count, 3);
        check("stats_tok_9", tok_count, 9);
`endif

        set_block(32, 0, 0, -48, 0, 0, 0, 0);
        apply_block();
        drain(100, 100, 5, fc);

        set_block(-16, -17, 2047, 2048, -2048, -2049, 1, -1);
        apply_block();
        drain(100, 100, 0, fc);

        set_block(32, 0, 0, -48, 0, 0, 0, 0);
        apply_block();
        out_ready = 1'b0;
        for (int k = 0; k < 20 && !out_valid; k++)
            @(negedge clk);
        check("reached_emit", out_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midblock_rst_out_valid", out_valid, 0);
        check("midblock_rst_in_ready", in_ready, 1);
        exp_q.delete();
        tok_done = 0;
        blk_done = 0;

        set_block(15, -1, 5000, -5000, 0, 0, 0, 16);
        apply_block();
        drain(100, 100, 0, fc);

        for (int b = 0; b < 40; b++) begin
            for (int i = 0; i < 8; i++) begin
                sel = int'($urandom_range(9));
                if (sel < 4)
                    coef_a[i] = 0;
                else if (sel < 6)
                    coef_a[i] = int'($urandom_range(80)) - 40;
                else if (sel < 8)
                    coef_a[i] = int'($urandom_range(6000)) - 3000;
                else
                    coef_a[i] = int'($urandom) >>> 13;
            end
            apply_block();
            drain(60, 80, 0, fc);
        end

`ifdef RLE_STATS_EN
        @(negedge clk);
        check("stats_blk_total", blk_count, blk_done);
        check("stats_tok_total", tok_count, tok_done);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
